// File: rtl/csr_defs.sv
// Shared CSR constants, trap cause codes and trap-arbiter encodings.
// Imported by the trap path and the CSR file.
package csr_defs;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [4:0] CAUSE_INST_MISALIGN = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL       = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT    = 5'd3;
  localparam logic [4:0] CAUSE_LD_MISALIGN   = 5'd4;
  localparam logic [4:0] CAUSE_ST_MISALIGN   = 5'd6;
  localparam logic [4:0] CAUSE_ECALL_U       = 5'd8;
  localparam logic [4:0] CAUSE_INST_PF       = 5'd12;
  localparam logic [4:0] CAUSE_LD_PF         = 5'd13;
  localparam logic [4:0] CAUSE_ST_PF         = 5'd15;

  localparam logic [1:0] FLUSH_NONE = 2'b00;
  localparam logic [1:0] FLUSH_ALL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN
  } trap_state_t;

  typedef enum logic [1:0] {
    STG_NONE,
    STG_IF,
    STG_ID,
    STG_MEM
  } trap_stage_t;

  typedef struct packed {
    logic mem_ld_mis;
    logic mem_st_mis;
    logic mem_ld_pf;
    logic mem_st_pf;
    logic id_illegal;
    logic id_ebreak;
    logic id_ecall;
    logic if_misalign;
    logic if_pf;
  } trap_req_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Picks the oldest faulting stage and its highest cause.
// Purely combinational; MEM beats ID beats IF.
module trap_prio_enc
  import csr_defs::*;
(
  input  trap_req_t   i_req,
  input  logic [1:0]  i_priv,
  output logic        o_valid,
  output logic [4:0]  o_cause,
  output trap_stage_t o_stage
);

  // First set request in age order wins
  always_comb begin
    o_valid = 1'b1;
    o_cause = 5'd0;
    o_stage = STG_NONE;
    priority case (1'b1)
      i_req.mem_ld_mis: begin
        o_cause = CAUSE_LD_MISALIGN;
        o_stage = STG_MEM;
      end
      i_req.mem_st_mis: begin
        o_cause = CAUSE_ST_MISALIGN;
        o_stage = STG_MEM;
      end
      i_req.mem_ld_pf: begin
        o_cause = CAUSE_LD_PF;
        o_stage = STG_MEM;
      end
      i_req.mem_st_pf: begin
        o_cause = CAUSE_ST_PF;
        o_stage = STG_MEM;
      end
      i_req.id_illegal: begin
        o_cause = CAUSE_ILLEGAL;
        o_stage = STG_ID;
      end
      i_req.id_ebreak: begin
        o_cause = CAUSE_BREAKPOINT;
        o_stage = STG_ID;
      end
      i_req.id_ecall: begin
        o_cause = CAUSE_ECALL_U + {3'd0, i_priv};
        o_stage = STG_ID;
      end
      i_req.if_misalign: begin
        o_cause = CAUSE_INST_MISALIGN;
        o_stage = STG_IF;
      end
      i_req.if_pf: begin
        o_cause = CAUSE_INST_PF;
        o_stage = STG_IF;
      end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/trap_arbiter.sv
// Trap arbiter: captures one exception, holds it for the CSR
// side until ack, then drains the flushed pipeline.
module trap_arbiter
  import csr_defs::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_misalign_i,
  input  logic        if_pf_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_va_i,
  input  logic        id_illegal_i,
  input  logic        id_ebreak_i,
  input  logic        id_ecall_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_inst_i,
  input  logic        mem_ld_mis_i,
  input  logic        mem_st_mis_i,
  input  logic        mem_ld_pf_i,
  input  logic        mem_st_pf_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_inst_i,
  input  logic [31:0] mem_va_i,
  input  logic [1:0]  priv_i,
  input  logic        trap_ack_i,
  output logic        trap_valid_o,
  output logic [4:0]  trap_id_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] fault_inst_o,
  output logic [31:0] fault_va_imem_o,
  output logic [31:0] fault_va_dmem_o,
  output logic [1:0]  flush_o,
  output logic        timeout_o
);

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
  localparam logic [7:0] TO_LIMIT   = 8'(ACK_TIMEOUT);

  trap_state_t r_state;
  logic        r_valid;
  logic [4:0]  r_id;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_va_imem;
  logic [31:0] r_va_dmem;
  logic [1:0]  r_flush;
  logic        r_timeout;
  logic [2:0]  r_drain_cnt;
  logic [7:0]  r_to_cnt;

  trap_req_t   w_req;
  logic        w_valid;
  logic [4:0]  w_cause;
  trap_stage_t w_stage;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic [31:0] w_va_imem;
  logic [31:0] w_va_dmem;
  logic [7:0]  w_to_next;

  assign w_req = '{
    mem_ld_mis:  mem_ld_mis_i,
    mem_st_mis:  mem_st_mis_i,
    mem_ld_pf:   mem_ld_pf_i,
    mem_st_pf:   mem_st_pf_i,
    id_illegal:  id_illegal_i,
    id_ebreak:   id_ebreak_i,
    id_ecall:    id_ecall_i,
    if_misalign: if_misalign_i,
    if_pf:       if_pf_i
  };

  trap_prio_enc u_prio (
    .i_req   (w_req),
    .i_priv  (priv_i),
    .o_valid (w_valid),
    .o_cause (w_cause),
    .o_stage (w_stage)
  );

  assign w_to_next = (r_to_cnt == 8'hFF) ? r_to_cnt
                                         : r_to_cnt + 8'd1;

  // Route the winning stage's PC, instruction and fault VA
  always_comb begin
    w_pc      = 32'd0;
    w_inst    = 32'd0;
    w_va_imem = 32'd0;
    w_va_dmem = 32'd0;
    unique case (w_stage)
      STG_MEM: begin
        w_pc      = mem_pc_i;
        w_inst    = mem_inst_i;
        w_va_dmem = mem_va_i;
      end
      STG_ID: begin
        w_pc   = id_pc_i;
        w_inst = id_inst_i;
      end
      STG_IF: begin
        w_pc      = if_pc_i;
        w_va_imem = if_va_i;
      end
      default: ;
    endcase
  end

  // Trap FSM with capture registers and both counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_id        <= 5'd0;
      r_pc        <= 32'd0;
      r_inst      <= 32'd0;
      r_va_imem   <= 32'd0;
      r_va_dmem   <= 32'd0;
      r_flush     <= FLUSH_NONE;
      r_timeout   <= 1'b0;
      r_drain_cnt <= 3'd0;
      r_to_cnt    <= 8'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state   <= ST_REQ;
            r_valid   <= 1'b1;
            r_flush   <= FLUSH_ALL;
            r_id      <= w_cause;
            r_pc      <= w_pc;
            r_inst    <= w_inst;
            r_va_imem <= w_va_imem;
            r_va_dmem <= w_va_dmem;
            r_to_cnt  <= 8'd0;
          end
        end
        ST_REQ: begin
          if (trap_ack_i) begin
            r_state     <= ST_DRAIN;
            r_valid     <= 1'b0;
            r_drain_cnt <= DRAIN_INIT;
          end else begin
            r_to_cnt <= w_to_next;
            if (w_to_next >= TO_LIMIT)
              r_timeout <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 3'd0) begin
            r_state <= ST_IDLE;
            r_flush <= FLUSH_NONE;
          end else begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign trap_valid_o    = r_valid;
  assign trap_id_o       = r_id;
  assign trap_pc_o       = r_pc;
  assign fault_inst_o    = r_inst;
  assign fault_va_imem_o = r_va_imem;
  assign fault_va_dmem_o = r_va_dmem;
  assign flush_o         = r_flush;
  assign timeout_o       = r_timeout;

endmodule

// File: tb/tb_trap_arbiter.sv
// Bench for trap_arbiter: directed scenarios plus randomized
// traps against a table-driven cause/priority model.
module tb_trap_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_misalign_i = 0, if_pf_i = 0;
  logic [31:0] if_pc_i = 0, if_va_i = 0;
  logic        id_illegal_i = 0, id_ebreak_i = 0, id_ecall_i = 0;
  logic [31:0] id_pc_i = 0, id_inst_i = 0;
  logic        mem_ld_mis_i = 0, mem_st_mis_i = 0;
  logic        mem_ld_pf_i = 0, mem_st_pf_i = 0;
  logic [31:0] mem_pc_i = 0, mem_inst_i = 0, mem_va_i = 0;
  logic [1:0]  priv_i = 2'd3;
  logic        trap_ack_i = 0;
  logic        trap_valid_o;
  logic [4:0]  trap_id_o;
  logic [31:0] trap_pc_o, fault_inst_o;
  logic [31:0] fault_va_imem_o, fault_va_dmem_o;
  logic [1:0]  flush_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  e_id;
  logic [31:0] e_pc, e_inst, e_vai, e_vad;

  always #5 clk = ~clk;

  trap_arbiter #(.DRAIN_CYCLES(2), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_misalign_i(if_misalign_i), .if_pf_i(if_pf_i),
    .if_pc_i(if_pc_i), .if_va_i(if_va_i),
    .id_illegal_i(id_illegal_i), .id_ebreak_i(id_ebreak_i),
    .id_ecall_i(id_ecall_i),
    .id_pc_i(id_pc_i), .id_inst_i(id_inst_i),
    .mem_ld_mis_i(mem_ld_mis_i), .mem_st_mis_i(mem_st_mis_i),
    .mem_ld_pf_i(mem_ld_pf_i), .mem_st_pf_i(mem_st_pf_i),
    .mem_pc_i(mem_pc_i), .mem_inst_i(mem_inst_i),
    .mem_va_i(mem_va_i),
    .priv_i(priv_i), .trap_ack_i(trap_ack_i),
    .trap_valid_o(trap_valid_o), .trap_id_o(trap_id_o),
    .trap_pc_o(trap_pc_o), .fault_inst_o(fault_inst_o),
    .fault_va_imem_o(fault_va_imem_o),
    .fault_va_dmem_o(fault_va_dmem_o),
    .flush_o(flush_o), .timeout_o(timeout_o)
  );

  // bit order, oldest/highest first:
  // 8 ld_mis 7 st_mis 6 ld_pf 5 st_pf 4 illegal
  // 3 ebreak 2 ecall 1 if_misalign 0 if_pf
  task automatic set_req(input logic [8:0] v);
    {mem_ld_mis_i, mem_st_mis_i, mem_ld_pf_i, mem_st_pf_i,
     id_illegal_i, id_ebreak_i, id_ecall_i,
     if_misalign_i, if_pf_i} = v;
  endtask

  task automatic rand_addrs;
    if_pc_i = $urandom; if_va_i = $urandom;
    id_pc_i = $urandom; id_inst_i = $urandom;
    mem_pc_i = $urandom; mem_inst_i = $urandom;
    mem_va_i = $urandom;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: scan request bits oldest-first, look up cause
  task automatic model(input logic [8:0] v, input logic [1:0] pv);
    int cause [9];
    cause = '{12, 0, 8 + int'(pv), 3, 2, 15, 13, 6, 4};
    e_id = 0; e_pc = 0; e_inst = 0; e_vai = 0; e_vad = 0;
    for (int b = 8; b >= 0; b--) begin
      if (v[b]) begin
        e_id = 5'(cause[b]);
        if (b >= 5) begin
          e_pc = mem_pc_i; e_inst = mem_inst_i; e_vad = mem_va_i;
        end else if (b >= 2) begin
          e_pc = id_pc_i; e_inst = id_inst_i;
        end else begin
          e_pc = if_pc_i; e_vai = if_va_i;
        end
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while ((flush_o !== 2'b00 || trap_valid_o !== 1'b0) && c < 20) begin
      tick;
      c++;
    end
    n_cmp++;
    if (flush_o !== 2'b00 || trap_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_wait: flush=%b valid=%b, need 00/0",
               tag, flush_o, trap_valid_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    n_cmp++;
    if ({trap_valid_o, trap_id_o, trap_pc_o, fault_inst_o,
         fault_va_imem_o, fault_va_dmem_o, flush_o, timeout_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b id=%0d pc=%h flush=%b to=%b, need all 0",
               trap_valid_o, trap_id_o, trap_pc_o, flush_o, timeout_o);
    end
  endtask

  task automatic test_st_pf;
    rand_addrs;
    mem_pc_i = 32'h80;
    mem_va_i = 32'h4000_0003;
    set_req(9'b0_0010_0000);
    tick;
    set_req('0);
    n_cmp++;
    if ({trap_valid_o, flush_o, trap_id_o, trap_pc_o, fault_va_dmem_o}
        !== {1'b1, 2'b11, 5'd15, 32'h80, 32'h4000_0003}) begin
      n_bad++;
      $display("FAIL st_pf: valid=%b flush=%b id=%0d pc=%h vad=%h, need 1 11 15 80 40000003",
               trap_valid_o, flush_o, trap_id_o, trap_pc_o, fault_va_dmem_o);
    end
    trap_ack_i = 1'b1;
    tick;
    trap_ack_i = 1'b0;
    wait_idle("st_pf");
  endtask

  task automatic test_stage_prio;
    rand_addrs;
    set_req(9'b1_0001_0001);
    tick;
    set_req('0);
    n_cmp++;
    if ({trap_id_o, trap_pc_o, fault_inst_o, fault_va_imem_o}
        !== {5'd4, mem_pc_i, mem_inst_i, 32'd0}) begin
      n_bad++;
      $display("FAIL stage_prio: id=%0d pc=%h inst=%h vai=%h, need 4 %h %h 0",
               trap_id_o, trap_pc_o, fault_inst_o, fault_va_imem_o,
               mem_pc_i, mem_inst_i);
    end
    trap_ack_i = 1'b1;
    tick;
    trap_ack_i = 1'b0;
    wait_idle("stage_prio");
  endtask

  task automatic test_ecall_priv;
    logic [1:0] pvs [3];
    logic [4:0] exp [3];
    pvs = '{2'd0, 2'd1, 2'd3};
    exp = '{5'd8, 5'd9, 5'd11};
    for (int i = 0; i < 3; i++) begin
      rand_addrs;
      priv_i = pvs[i];
      set_req(9'b0_0000_0100);
      tick;
      set_req('0);
      n_cmp++;
      if ({trap_id_o, trap_pc_o} !== {exp[i], id_pc_i}) begin
        n_bad++;
        $display("FAIL ecall_priv%0d: id=%0d pc=%h, need %0d %h",
                 pvs[i], trap_id_o, trap_pc_o, exp[i], id_pc_i);
      end
      trap_ack_i = 1'b1;
      tick;
      trap_ack_i = 1'b0;
      wait_idle("ecall_priv");
    end
  endtask

  task automatic test_drain;
    logic       ev [5];
    logic [1:0] ef [5];
    int nf = 0;
    ev = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ef = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    rand_addrs;
    set_req(9'b0_0000_0010);
    for (int c = 0; c < 5; c++) begin
      tick;
      trap_ack_i = (c == 0);
      if (c == 0) set_req(9'b1_0001_0000);
      if (c == 3) set_req('0);
      if (flush_o === 2'b11) nf++;
      n_cmp++;
      if ({trap_valid_o, flush_o} !== {ev[c], ef[c]}) begin
        n_bad++;
        $display("FAIL drain_c%0d: valid=%b flush=%b, need %b %b",
                 c + 1, trap_valid_o, flush_o, ev[c], ef[c]);
      end
    end
    trap_ack_i = 1'b0;
    n_cmp++;
    if (nf != 3) begin
      n_bad++;
      $display("FAIL drain_len: flush cycles=%0d, need 3", nf);
    end
  endtask

  task automatic test_random;
    logic [1:0] pvs [3];
    pvs = '{2'd0, 2'd1, 2'd3};
    for (int it = 0; it < 40; it++) begin
      logic [8:0] v;
      int k, d;
      rand_addrs;
      priv_i = pvs[$urandom_range(0, 2)];
      v = 9'($urandom_range(1, 511));
      model(v, priv_i);
      set_req(v);
      tick;
      k = $urandom_range(1, 4);
      for (int j = 1; j <= k; j++) begin
        n_cmp++;
        if ({trap_valid_o, flush_o, trap_id_o, trap_pc_o, fault_inst_o,
             fault_va_imem_o, fault_va_dmem_o, timeout_o}
            !== {1'b1, 2'b11, e_id, e_pc, e_inst, e_vai, e_vad, 1'b0}) begin
          n_bad++;
          $display("FAIL rand%0d_req%0d: v=%h id=%0d pc=%h inst=%h vai=%h vad=%h, need id=%0d pc=%h inst=%h vai=%h vad=%h",
                   it, j, v, trap_id_o, trap_pc_o, fault_inst_o,
                   fault_va_imem_o, fault_va_dmem_o,
                   e_id, e_pc, e_inst, e_vai, e_vad);
        end
        set_req(9'($urandom));
        priv_i = pvs[$urandom_range(0, 2)];
        rand_addrs;
        trap_ack_i = (j == k);
        tick;
      end
      d = 0;
      while (flush_o === 2'b11 && d < 10) begin
        n_cmp++;
        if (trap_valid_o !== 1'b0) begin
          n_bad++;
          $display("FAIL rand%0d_drain_valid: %b, need 0", it, trap_valid_o);
        end
        set_req(9'($urandom));
        trap_ack_i = 1'($urandom);
        d++;
        tick;
      end
      set_req('0);
      trap_ack_i = 1'b0;
      n_cmp++;
      if (d != 2 || trap_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL rand%0d_drain_len: cycles=%0d valid=%b, need 2 0",
                 it, d, trap_valid_o);
      end
    end
  endtask

  task automatic test_timeout;
    rand_addrs;
    set_req(9'b0_0000_1000);
    tick;
    set_req('0);
    for (int t = 1; t <= 15; t++) begin
      n_cmp++;
      if (timeout_o !== 1'b0 || trap_valid_o !== 1'b1) begin
        n_bad++;
        $display("FAIL timeout_early%0d: to=%b valid=%b, need 0 1",
                 t, timeout_o, trap_valid_o);
      end
      tick;
    end
    for (int t = 0; t < 4; t++) begin
      n_cmp++;
      if (timeout_o !== 1'b1 || trap_valid_o !== 1'b1) begin
        n_bad++;
        $display("FAIL timeout_set%0d: to=%b valid=%b, need 1 1",
                 t, timeout_o, trap_valid_o);
      end
      if (t < 3) tick;
    end
    trap_ack_i = 1'b1;
    tick;
    trap_ack_i = 1'b0;
    n_cmp++;
    if ({trap_valid_o, flush_o, timeout_o} !== {1'b0, 2'b11, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_ack: valid=%b flush=%b to=%b, need 0 11 1",
               trap_valid_o, flush_o, timeout_o);
    end
    wait_idle("timeout");
    n_cmp++;
    if (timeout_o !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: to=%b, need 1", timeout_o);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset_drain;
    rand_addrs;
    set_req(9'b0_0100_0000);
    tick;
    set_req('0);
    trap_ack_i = 1'b1;
    tick;
    trap_ack_i = 1'b0;
    tick;
    n_cmp++;
    if (flush_o !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_drain_pre: flush=%b, need 11", flush_o);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if ({trap_valid_o, trap_id_o, trap_pc_o, fault_inst_o,
         fault_va_imem_o, fault_va_dmem_o, flush_o, timeout_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_drain_clear: valid=%b id=%0d pc=%h flush=%b, need all 0",
               trap_valid_o, trap_id_o, trap_pc_o, flush_o);
    end
    rand_addrs;
    set_req(9'b0_0000_0001);
    model(9'b0_0000_0001, priv_i);
    tick;
    set_req('0);
    n_cmp++;
    if ({trap_valid_o, flush_o, trap_id_o, trap_pc_o, fault_inst_o,
         fault_va_imem_o} !== {1'b1, 2'b11, 5'd12, e_pc, 32'd0, e_vai}) begin
      n_bad++;
      $display("FAIL rst_drain_new: valid=%b flush=%b id=%0d pc=%h inst=%h vai=%h, need 1 11 12 %h 0 %h",
               trap_valid_o, flush_o, trap_id_o, trap_pc_o, fault_inst_o,
               fault_va_imem_o, e_pc, e_vai);
    end
    trap_ack_i = 1'b1;
    tick;
    trap_ack_i = 1'b0;
    wait_idle("rst_drain");
  endtask

  initial begin
    test_reset;
    test_st_pf;
    test_stage_prio;
    test_ecall_priv;
    test_drain;
    test_random;
    test_timeout;
    test_reset_drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_arbiter.md
TRAP_ARBITER -- requirements
Module: trap_arbiter

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles flush_o stays 2'b11 after trap_ack_i (range 1-7).
REQ-002 Parameter ACK_TIMEOUT, default 15: cycles in REQ without ack before timeout_o sets (range 1-255).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_misalign_i, if_pf_i  input  1 each  IF-stage misaligned fetch, instruction page fault.
REQ-006 if_pc_i, if_va_i  input  32 each  IF PC, faulting fetch VA.
REQ-007 id_illegal_i, id_ebreak_i, id_ecall_i  input  1 each  ID-stage illegal instruction, ebreak, ecall.
REQ-008 id_pc_i, id_inst_i  input  32 each  ID PC and instruction.
REQ-009 mem_ld_mis_i, mem_st_mis_i, mem_ld_pf_i, mem_st_pf_i  input  1 each  MEM-stage load/store misaligned, load/store page fault.
REQ-010 mem_pc_i, mem_inst_i, mem_va_i  input  32 each  MEM PC, instruction, faulting data VA.
REQ-011 priv_i  input  2  current privilege (0 U, 1 S, 3 M).
REQ-012 trap_ack_i  input  1  CSR side has taken the trap (CSR branch signal).
REQ-013 trap_valid_o  output  1  trap presented to CSR side.
REQ-014 trap_id_o  output  5  RISC-V exception cause code.
REQ-015 trap_pc_o, fault_inst_o, fault_va_imem_o, fault_va_dmem_o  output  32 each  captured trap PC, instruction, IMEM VA, DMEM VA.
REQ-016 flush_o  output  2  2'b11 = flush whole pipeline, 2'b00 = none.
REQ-017 timeout_o  output  1  sticky: ack not received within ACK_TIMEOUT.

Function
REQ-018 FSM states IDLE, REQ, DRAIN; only IDLE accepts requests.
REQ-019 IDLE: any request input high -> capture winner, go to REQ next cycle; otherwise stay.
REQ-020 Stage priority: MEM > ID > IF (oldest instruction wins).
REQ-021 MEM order: ld_mis (4), st_mis (6), ld_pf (13), st_pf (15).
REQ-022 ID order: illegal (2), ebreak (3), ecall (8 + priv_i: U->8, S->9, M->11).
REQ-023 IF order: misalign (0), pf (12).
REQ-024 Captured trap_pc_o and fault_inst_o come from the winning stage; IF win: fault_inst_o = 0.
REQ-025 fault_va_imem_o = if_va_i on IF win, else 0; fault_va_dmem_o = mem_va_i on MEM win, else 0.
REQ-026 REQ: trap_valid_o = 1, flush_o = 2'b11, captured outputs held stable until ack.
REQ-027 REQ with trap_ack_i = 1 -> DRAIN next cycle, drain counter loaded with DRAIN_CYCLES-1.
REQ-028 DRAIN: trap_valid_o = 0, flush_o = 2'b11; counter decrements; at 0 -> IDLE next cycle.
REQ-029 Requests during REQ/DRAIN are ignored (from flushed instructions); one IDLE cycle with flush_o = 2'b00 is required between traps.
REQ-030 trap_ack_i outside REQ is ignored.
REQ-031 REQ timeout counter, 8-bit, saturating, clears on REQ entry; reaching ACK_TIMEOUT sets timeout_o; FSM stays in REQ.
REQ-032 Latency: request at cycle N -> trap_valid_o and flush_o high at N+1; flush_o low at N+1+k+DRAIN_CYCLES, k = ack wait cycles (ack at N+1 gives k = 1).

Reset
REQ-033 rst, when sampled high, takes priority over all events, including mid-REQ or mid-DRAIN.
REQ-034 After reset: state IDLE; trap_valid_o 0, trap_id_o 0, all 32-bit outputs 0, flush_o 2'b00, timeout_o 0, counters 0.

Structure
REQ-035 Cause codes, FSM state encoding and flush encodings SHALL live in the shared csr_defs package with the CSR constants.
REQ-036 Priority selection SHALL be one combinational sub-module, trap_prio_enc (request vector + priv_i -> valid, cause, stage select); FSM, capture registers and counters stay in trap_arbiter.

Verification
REQ-037 mem_st_pf_i=1, mem_pc_i=0x80, mem_va_i=0x4000_0003 -> next cycle trap_valid_o=1, trap_id_o=15, trap_pc_o=0x80, fault_va_dmem_o=0x4000_0003, flush_o=2'b11.
REQ-038 Same cycle if_pf_i, id_illegal_i, mem_ld_mis_i -> trap_id_o=4, trap_pc_o=mem_pc_i.
REQ-039 id_ecall_i with priv_i=0, 1, 3 in three separate traps -> trap_id_o=8, 9, 11.
REQ-040 Ack in the first REQ cycle, DRAIN_CYCLES=2 -> flush_o=2'b11 for exactly 3 cycles; request held during DRAIN is ignored.
REQ-041 No ack for 15 REQ cycles -> timeout_o=1 and stays 1; later ack -> DRAIN, then IDLE.
REQ-042 rst in the second DRAIN cycle -> next cycle all outputs 0, state IDLE, a new request is accepted.
